pipe_stage_hs: RTL and testbench
================================

// Module: pipe_stage_hs
// PURPOSE
//  Parametrised handshake pipeline register for inter-stage boundaries (EX/MEM, MEM/WB, ...).
//  Carries a control field, two data words and a destination register address.
//  Adds valid/ready flow control, synchronous flush and an optional 2-entry skid buffer.
//  Bubbles never leak control: out_ctrl is zero whenever out_valid is low.
// PARAMETERS
//  WIDTH   32  data word width (in_data0/1, out_data0/1)
//  CTRL_W  2   control field width (e.g. {MEMTOREG, REGWRITE})
//  ADDR_W  5   destination register address width
//  SKID    1   1: 2-entry skid buffer, registered in_ready; 0: single entry, combinational in_ready
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-low
//  flush      in   1        synchronous flush, empties the stage
//  in_valid   in   1        upstream entry valid
//  in_ready   out  1        stage can accept an entry
//  in_ctrl    in   CTRL_W   control field
//  in_data0   in   WIDTH    data word 0 (e.g. memory read data)
//  in_data1   in   WIDTH    data word 1 (e.g. ALU result)
//  in_rd      in   ADDR_W   destination register address
//  out_valid  out  1        head entry valid
//  out_ready  in   1        downstream accepts head entry
//  out_ctrl   out  CTRL_W   head control; forced 0 when !out_valid
//  out_data0  out  WIDTH    head data word 0
//  out_data1  out  WIDTH    head data word 1
//  out_rd     out  ADDR_W   head destination address
//  occupancy  out  2        entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
//  Reset: rst low -> immediately empty; out_valid=0, out_ctrl/data/rd=0, occupancy=0.
//   When SKID=1, in_ready=0 while rst is low and goes to 1 on the first clock edge after release.
//  Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; both sampled at posedge.
//  Latency: accepted entry appears on out_* the next cycle when the stage was empty.
//   Throughput is 1 entry/cycle while out_ready=1.
//  Order: strict FIFO; no entry is lost or duplicated except on flush.
//  SKID=1 states: EMPTY, ONE (main reg), TWO (main + skid reg).
//   in_ready = (state != TWO), registered, with no comb path from out_ready.
//   EMPTY: in_fire -> ONE, main<=in.
//   ONE: in_fire & out_fire -> ONE, main<=in.
//   ONE: in_fire & !out_fire -> TWO, skid<=in.
//   ONE: !in_fire & out_fire -> EMPTY.
//   ONE: no fire -> hold.
//   TWO: out_fire -> ONE, main<=skid; otherwise hold.
//  SKID=0 states: EMPTY, ONE only.
//   in_ready = !out_valid | out_ready (comb).
//   Simultaneous in_fire & out_fire -> main<=in, stays ONE.
//  Payload regs load only on acceptance; held stable while out_valid & !out_ready.
//  out_data0/1/rd are don't-care when !out_valid; out_ctrl is always 0 when !out_valid.
//  Flush: highest priority. Next state EMPTY, occupancy 0.
//   An entry offered with in_fire in the flush cycle is dropped.
//   An out_fire in the flush cycle still counts downstream (the head was presented).
//  Reset mid-operation: all entries discarded asynchronously; no partial state survives.
//  occupancy: EMPTY=0, ONE=1, TWO=2; registered, updates with the state.
// TESTING
//  1 Reset: hold rst=0 with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0.
//    Release -> in_ready=1 by the next edge.
//  2 Stream: out_ready=1, push rd=1..8, data1=0x10..0x17, ctrl=2'b11 each cycle ->
//    same sequence on out_*, one cycle later, no bubbles.
//  3 Backpressure (SKID=1): out_ready=0, push A,B,C -> A,B accepted, occupancy=2, in_ready=0, C held.
//    Raise out_ready -> out A,B,C in order.
//  4 Flush: occupancy=2 with in_valid=1 and flush=1 for one cycle -> next cycle
//    out_valid=0, out_ctrl=0, occupancy=0, incoming entry dropped.
//  5 Async reset mid-stream: drop rst between edges -> outputs 0 immediately, without waiting for clk.
//  6 SKID=0 build: out_ready=0 -> in_ready=0 same cycle; toggle out_ready randomly 1000 cycles ->
//    scoreboard shows in-order, lossless delivery.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: handshake pipeline register between pipeline stages.
// Carries {ctrl, data0, data1, rd} with valid/ready flow control, a
// synchronous flush and an optional second (skid) entry.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (in_fire on the upstream side, out_fire on the downstream side).
// A producer holds valid and its payload stable until the transfer happens.
// While out_valid is high and out_ready is low, the head entry stays stable.
//
// The FSM state is visible on occupancy (EMPTY=0, ONE=1, TWO=2).

module pipe_stage_hs #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 2,
  parameter int ADDR_W = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [WIDTH-1:0]  in_data0,
  input  logic [WIDTH-1:0]  in_data1,
  input  logic [ADDR_W-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [WIDTH-1:0]  out_data0,
  output logic [WIDTH-1:0]  out_data1,
  output logic [ADDR_W-1:0] out_rd,
  output logic [1:0]        occupancy
);

  localparam bit USE_SKID = (SKID != 0);

  // Encoding doubles as the entry count driven on occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Main register is the head entry; skid register holds the second entry.
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [WIDTH-1:0]  main_d0_q;
  logic [WIDTH-1:0]  main_d1_q;
  logic [ADDR_W-1:0] main_rd_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [WIDTH-1:0]  skid_d0_q;
  logic [WIDTH-1:0]  skid_d1_q;
  logic [ADDR_W-1:0] skid_rd_q;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  generate
    if (USE_SKID) begin : g_skid
      logic in_ready_q;

      // Registered ready: low in reset, high unless the next state is full.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          in_ready_q <= 1'b0;
        end else begin
          in_ready_q <= (state_d != ST_TWO);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      // Single entry: accept when empty or when the head leaves this cycle.
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Next-state and payload load selection; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire && !out_fire) begin
            // Only reachable with a skid entry; without it in_ready implies out_fire.
            if (USE_SKID) begin
              state_d   = ST_TWO;
              load_skid = 1'b1;
            end
          end else if (!in_fire && out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State register; reset empties the stage immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Head payload: loads from the input or promotes the skid entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_ctrl_q <= '0;
      main_d0_q   <= '0;
      main_d1_q   <= '0;
      main_rd_q   <= '0;
    end else if (load_main_in) begin
      main_ctrl_q <= in_ctrl;
      main_d0_q   <= in_data0;
      main_d1_q   <= in_data1;
      main_rd_q   <= in_rd;
    end else if (load_main_skid) begin
      main_ctrl_q <= skid_ctrl_q;
      main_d0_q   <= skid_d0_q;
      main_d1_q   <= skid_d1_q;
      main_rd_q   <= skid_rd_q;
    end
  end

  // Skid payload: captures the entry that arrives while the head is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_ctrl_q <= '0;
      skid_d0_q   <= '0;
      skid_d1_q   <= '0;
      skid_rd_q   <= '0;
    end else if (load_skid) begin
      skid_ctrl_q <= in_ctrl;
      skid_d0_q   <= in_data0;
      skid_d1_q   <= in_data1;
      skid_rd_q   <= in_rd;
    end
  end

  // Control is gated so a bubble never carries a live control field.
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data0 = main_d0_q;
  assign out_data1 = main_d1_q;
  assign out_rd    = main_rd_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: a SKID=1 instance (a_*) and a SKID=0 instance (b_*)
// checked every cycle against a FIFO-of-entries reference model.

module tb_pipe_stage_hs;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 2;
  localparam int ADDR_W = 5;
  localparam int EW     = CTRL_W + 2 * WIDTH + ADDR_W;

  logic clk;
  logic rst;
  logic flush;

  logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CTRL_W-1:0] a_in_ctrl, a_out_ctrl;
  logic [WIDTH-1:0]  a_in_d0, a_in_d1, a_out_d0, a_out_d1;
  logic [ADDR_W-1:0] a_in_rd, a_out_rd;
  logic [1:0]        a_occ;

  logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CTRL_W-1:0] b_in_ctrl, b_out_ctrl;
  logic [WIDTH-1:0]  b_in_d0, b_in_d1, b_out_d0, b_out_d1;
  logic [ADDR_W-1:0] b_in_rd, b_out_rd;
  logic [1:0]        b_occ;

  int checks   = 0;
  int failures = 0;

  // Reference model: entries held by each stage, head at index 0.
  logic [EW-1:0] exp_qa[$];
  logic [EW-1:0] exp_qb[$];
  bit armed_a = 1'b0;
  int acc_a = 0;
  int acc_b = 0;
  bit a_inf, a_outf, b_inf, b_outf;
  logic [EW-1:0] ha, hb;

  pipe_stage_hs #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .SKID(1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl),
    .in_data0(a_in_d0), .in_data1(a_in_d1), .in_rd(a_in_rd),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
    .out_data0(a_out_d0), .out_data1(a_out_d1), .out_rd(a_out_rd),
    .occupancy(a_occ)
  );

  pipe_stage_hs #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .SKID(0)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl),
    .in_data0(b_in_d0), .in_data1(b_in_d1), .in_rd(b_in_rd),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
    .out_data0(b_out_d0), .out_data1(b_out_d1), .out_rd(b_out_rd),
    .occupancy(b_occ)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack_a();
    return {a_in_ctrl, a_in_d0, a_in_d1, a_in_rd};
  endfunction

  function automatic logic [EW-1:0] pack_b();
    return {b_in_ctrl, b_in_d0, b_in_d1, b_in_rd};
  endfunction

  // Model update: a stage is a FIFO of capacity 2 (a) or 1 (b).
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        exp_qa.delete();
        exp_qb.delete();
        armed_a = 1'b0;
      end else begin
        a_inf  = a_in_valid && armed_a && (exp_qa.size() < 2);
        a_outf = (exp_qa.size() != 0) && a_out_ready;
        b_inf  = b_in_valid && ((exp_qb.size() == 0) || b_out_ready);
        b_outf = (exp_qb.size() != 0) && b_out_ready;
        if (a_inf) acc_a++;
        if (b_inf) acc_b++;
        if (flush) begin
          exp_qa.delete();
          exp_qb.delete();
        end else begin
          if (a_outf) void'(exp_qa.pop_front());
          if (a_inf) exp_qa.push_back(pack_a());
          if (b_outf) void'(exp_qb.pop_front());
          if (b_inf) exp_qb.push_back(pack_b());
        end
        armed_a = 1'b1;
      end
    end
  end

  // Scoreboard: compare both stages to the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      ha = (exp_qa.size() != 0) ? exp_qa[0] : '0;
      hb = (exp_qb.size() != 0) ? exp_qb[0] : '0;
      check_eq("a_valid", 128'(a_out_valid), 128'(exp_qa.size() != 0));
      check_eq("a_ctrl", 128'(a_out_ctrl), 128'(ha[EW-1 -: CTRL_W]));
      if (exp_qa.size() != 0)
        check_eq("a_payload", 128'({a_out_d0, a_out_d1, a_out_rd}), 128'(ha[EW-CTRL_W-1:0]));
      check_eq("a_occ", 128'(a_occ), 128'(exp_qa.size()));
      check_eq("a_in_ready", 128'(a_in_ready), 128'(armed_a && (exp_qa.size() < 2)));
      check_eq("b_valid", 128'(b_out_valid), 128'(exp_qb.size() != 0));
      check_eq("b_ctrl", 128'(b_out_ctrl), 128'(hb[EW-1 -: CTRL_W]));
      if (exp_qb.size() != 0)
        check_eq("b_payload", 128'({b_out_d0, b_out_d1, b_out_rd}), 128'(hb[EW-CTRL_W-1:0]));
      check_eq("b_occ", 128'(b_occ), 128'(exp_qb.size()));
      check_eq("b_in_ready", 128'(b_in_ready), 128'((exp_qb.size() == 0) || b_out_ready));
    end
  end

  // Offer one entry to stage a until the model accepts it; call at posedge+1.
  task automatic push_a(input logic [EW-1:0] e, input int limit, output int waited);
    int start;
    start = acc_a;
    {a_in_ctrl, a_in_d0, a_in_d1, a_in_rd} = e;
    a_in_valid = 1'b1;
    waited = 0;
    while (acc_a == start && waited < limit) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_eq("a_push_accept", 128'(acc_a - start), 128'(1));
    a_in_valid = 1'b0;
  endtask

  task automatic push_b(input logic [EW-1:0] e, input int limit, output int waited);
    int start;
    start = acc_b;
    {b_in_ctrl, b_in_d0, b_in_d1, b_in_rd} = e;
    b_in_valid = 1'b1;
    waited = 0;
    while (acc_b == start && waited < limit) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_eq("b_push_accept", 128'(acc_b - start), 128'(1));
    b_in_valid = 1'b0;
  endtask

  function automatic logic [EW-1:0] mk(input logic [1:0] c, input logic [31:0] d1, input logic [4:0] rd);
    logic [31:0] d0;
    d0 = $urandom();
    return {c, d0, d1, rd};
  endfunction

  initial begin
    int w;
    int base;
    int last;
    logic [31:0] d1;

    // Reset held with valid offered
    rst = 1'b0;
    flush = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 2'b11; a_in_d0 = 32'h1; a_in_d1 = 32'h2; a_in_rd = 5'd3;
    b_in_valid = 1'b1; b_in_ctrl = 2'b11; b_in_d0 = 32'h1; b_in_d1 = 32'h2; b_in_rd = 5'd3;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_valid", 128'(a_out_valid), 128'(0));
    check_eq("rst_a_ctrl", 128'(a_out_ctrl), 128'(0));
    check_eq("rst_a_occ", 128'(a_occ), 128'(0));
    check_eq("rst_a_rdy", 128'(a_in_ready), 128'(0));
    check_eq("rst_b_valid", 128'(b_out_valid), 128'(0));
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rel_a_rdy_before", 128'(a_in_ready), 128'(0));
    @(posedge clk);
    #1;
    check_eq("rel_a_rdy_after", 128'(a_in_ready), 128'(1));

    // Stream with out_ready held high
    for (int i = 1; i <= 8; i++) begin
      d1 = 32'h10 + 32'(i - 1);
      push_a(mk(2'b11, d1, 5'(i)), 4, w);
      check_eq("stream_lat", 128'(w), 128'(1));
      check_eq("stream_valid", 128'(a_out_valid), 128'(1));
      check_eq("stream_rd", 128'(a_out_rd), 128'(i));
      check_eq("stream_d1", 128'(a_out_d1), 128'(d1));
    end
    @(posedge clk);
    #1;
    check_eq("stream_drained", 128'(a_occ), 128'(0));

    // Backpressure: A,B accepted, C held
    a_out_ready = 1'b0;
    push_a(mk(2'b01, 32'hA, 5'd10), 4, w);
    push_a(mk(2'b10, 32'hB, 5'd11), 4, w);
    {a_in_ctrl, a_in_d0, a_in_d1, a_in_rd} = mk(2'b11, 32'hC, 5'd12);
    a_in_valid = 1'b1;
    base = acc_a;
    repeat (2) @(posedge clk);
    #1;
    check_eq("bp_occ", 128'(a_occ), 128'(2));
    check_eq("bp_rdy", 128'(a_in_ready), 128'(0));
    check_eq("bp_head", 128'(a_out_rd), 128'(10));
    check_eq("bp_c_held", 128'(acc_a - base), 128'(0));
    a_out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_order_a", 128'(a_out_rd), 128'(10));
    @(negedge clk);
    check_eq("bp_order_b", 128'(a_out_rd), 128'(11));
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_order_c", 128'(a_out_rd), 128'(12));
    @(posedge clk);
    #1;

    // Flush while full with an entry offered
    a_out_ready = 1'b0;
    push_a(mk(2'b11, 32'h20, 5'd20), 4, w);
    push_a(mk(2'b11, 32'h21, 5'd21), 4, w);
    check_eq("fl_pre_occ", 128'(a_occ), 128'(2));
    {a_in_ctrl, a_in_d0, a_in_d1, a_in_rd} = mk(2'b11, 32'h22, 5'd22);
    a_in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    a_in_valid = 1'b0;
    check_eq("fl_valid", 128'(a_out_valid), 128'(0));
    check_eq("fl_ctrl", 128'(a_out_ctrl), 128'(0));
    check_eq("fl_occ", 128'(a_occ), 128'(0));
    @(posedge clk);
    #1;
    check_eq("fl_dropped", 128'(a_occ), 128'(0));

    // Asynchronous reset between edges
    push_a(mk(2'b11, 32'h25, 5'd25), 4, w);
    push_a(mk(2'b11, 32'h26, 5'd26), 4, w);
    {a_in_ctrl, a_in_d0, a_in_d1, a_in_rd} = mk(2'b11, 32'h27, 5'd27);
    a_in_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_eq("ar_valid", 128'(a_out_valid), 128'(0));
    check_eq("ar_ctrl", 128'(a_out_ctrl), 128'(0));
    check_eq("ar_rd", 128'(a_out_rd), 128'(0));
    check_eq("ar_d1", 128'(a_out_d1), 128'(0));
    check_eq("ar_occ", 128'(a_occ), 128'(0));
    check_eq("ar_rdy", 128'(a_in_ready), 128'(0));
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ar_rel_rdy", 128'(a_in_ready), 128'(1));

    // Random traffic on the skid stage, occasional flush
    last = acc_a;
    for (int n = 0; n < 400; n++) begin
      if (!a_in_valid || acc_a != last) begin
        a_in_valid = ($urandom_range(0, 3) != 0);
        {a_in_ctrl, a_in_d0, a_in_d1, a_in_rd} = mk(2'($urandom_range(0, 3)), $urandom(), 5'($urandom_range(0, 31)));
      end
      last = acc_a;
      a_out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 31) == 0);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rnd_a_empty", 128'(a_occ), 128'(0));

    // Single-entry stage: combinational ready
    b_out_ready = 1'b0;
    push_b(mk(2'b10, 32'h33, 5'd3), 4, w);
    @(negedge clk);
    check_eq("b_rdy_stall", 128'(b_in_ready), 128'(0));
    b_out_ready = 1'b1;
    #1;
    check_eq("b_rdy_comb_hi", 128'(b_in_ready), 128'(1));
    b_out_ready = 1'b0;
    #1;
    check_eq("b_rdy_comb_lo", 128'(b_in_ready), 128'(0));
    @(posedge clk);
    #1;

    last = acc_b;
    for (int n = 0; n < 1000; n++) begin
      if (!b_in_valid || acc_b != last) begin
        b_in_valid = ($urandom_range(0, 3) != 0);
        {b_in_ctrl, b_in_d0, b_in_d1, b_in_rd} = mk(2'($urandom_range(0, 3)), $urandom(), 5'($urandom_range(0, 31)));
      end
      last = acc_b;
      b_out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rnd_b_empty", 128'(b_occ), 128'(0));
    check_eq("rnd_b_valid", 128'(b_out_valid), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
